dcache_wb_buffer: RTL and testbench
===================================

# dcache_wb_buffer

Write-back (victim) buffer directly downstream of the Dcache eviction outputs. On every Dcache line fill that displaces a valid dirty line, it captures the evicted address and data and drains them to memory as 64-bit stores, one at a time, through the data-memory arbiter. Missing loads search it in parallel so that an in-flight victim is never lost or re-fetched stale. Only dirty victims are pushed; the Dcache controller gates the push with `evicted_valid_out & evicted_dirty_out`.

## Interface
- WB_DEPTH, 4: number of buffer entries; power of two, ≥2.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clock.
- push_en  in  1  capture victim this cycle.
- push_addr  in  SASS_ADDR (64)  evicted line address; `ignore` bits are 0.
- push_data  in  64  evicted line data.
- wb_full  out  1  count == WB_DEPTH; the controller must not push while high.
- wb_count  out  $clog2(WB_DEPTH)+1  occupied entries.
- wb_empty  out  1  count == 0; used by halt logic as "drained".
- lookup_en  in  1  a load-miss address is presented.
- lookup_addr  in  SASS_ADDR (64)  load-miss address.
- lookup_hit  out  1  a valid entry matches lookup_addr.
- lookup_data  out  64  data of the matching entry; 0 on miss.
- mem_st_valid  out  1  store request pending (head valid).
- mem_st_addr  out  SASS_ADDR (64)  head entry address.
- mem_st_data  out  64  head entry data.
- mem_st_accept  in  1  arbiter granted and memory returned nonzero response this cycle.

## Operation
- Circular FIFO: head ptr, tail ptr, and a count, plus per-entry valid/addr/data registers.
- Address match compares `tag` and `set_index` only.
- Push (push_en & !wb_full):
  - if a valid entry other than one being popped this cycle matches push_addr, overwrite its data in place (coalesce); tail and count unchanged.
  - otherwise write at tail, set valid, advance tail (wrap at WB_DEPTH), increment count.
- Push while wb_full: ignored, no state change. This is a protocol violation; the bench asserts it never happens.
- Pop (mem_st_accept & mem_st_valid): clear head valid, advance head with wrap, decrement count. mem_st_accept while empty is ignored.
- Push and pop in the same cycle: both take effect, and count is net unchanged.
- If the coalesce target is the head being popped this cycle, the old data is stored, and the push allocates a new entry at tail.
- Coalescing guarantees at most one match per address, so lookup needs no priority.
- Lookup is combinational over registered state only, gated by lookup_en. There is no bypass of a same-cycle push.
- mem_st_addr and mem_st_data are 0 when empty.
- No internal reordering: stores leave in push order, except for in-place coalesced data updates.

## Timing
- Reset values:
  - all entries invalid, head = tail = 0, count = 0.
  - wb_full = 0, wb_empty = 1, mem_st_valid = 0, lookup_hit = 0.
  - all data and address outputs 0.
- Push latency: entry visible on lookup and on mem_st_* the cycle after the push edge.
- Minimum push-to-memory latency is one cycle, giving one store per cycle maximum throughput.
- mem_st_valid stays high, with stable addr/data, until accepted. Only a coalesce into the head may change mem_st_data while it is waiting.
- wb_full and wb_count update on the same edge as the push or pop.
- Reset mid-drain discards all entries; the next cycle, mem_st_valid = 0.

## Test plan
- Reset, then idle:
  - wb_empty = 1, mem_st_valid = 0.
  - lookup_en with addr 0x100 gives lookup_hit = 0, data 0.
- Push 0x100/0xAA with accept held low:
  - next cycle mem_st_valid = 1, addr 0x100, data 0xAA, wb_count = 1.
  - lookup 0x100 gives hit with data 0xAA.
  - assert accept for one cycle, then wb_empty = 1.
- Fill to full:
  - push 0x0, 0x8, 0x10, 0x18 on consecutive cycles, accept low; wb_full = 1.
  - push 0x20 with accept high the same cycle is not accepted because full; 0x0 pops and count = 3.
  - the next push of 0x20 lands at wrapped slot 0.
- Coalesce:
  - push 0x40/0x1, then 0x40/0x2; wb_count = 1.
  - the drained store is 0x40/0x2.
- Coalesce into head during pop:
  - head is 0x40/0x1 with accept high, and 0x40/0x2 is pushed the same cycle.
  - the store issues 0x40/0x1 and count stays 1.
  - the next store is 0x40/0x2.
- Reset asserted with 3 entries pending:
  - the next cycle wb_count = 0 and mem_st_valid = 0.
  - lookup of any prior address misses.

Source files
------------

// File: rtl/dcache_wb_buffer_if.sv
// Bundle of the victim-buffer push, load-miss lookup and memory-store signals.
// "master" is the Dcache/arbiter side; "slave" is the buffer itself.
interface dcache_wb_buffer_if #(
  parameter int WB_DEPTH = 4
);
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  logic             push_en;
  logic [63:0]      push_addr;
  logic [63:0]      push_data;
  logic             wb_full;
  logic [CNT_W-1:0] wb_count;
  logic             wb_empty;
  logic             lookup_en;
  logic [63:0]      lookup_addr;
  logic             lookup_hit;
  logic [63:0]      lookup_data;
  logic             mem_st_valid;
  logic [63:0]      mem_st_addr;
  logic [63:0]      mem_st_data;
  logic             mem_st_accept;

  modport master (
    output push_en, push_addr, push_data, lookup_en, lookup_addr, mem_st_accept,
    input  wb_full, wb_count, wb_empty, lookup_hit, lookup_data,
           mem_st_valid, mem_st_addr, mem_st_data
  );

  modport slave (
    input  push_en, push_addr, push_data, lookup_en, lookup_addr, mem_st_accept,
    output wb_full, wb_count, wb_empty, lookup_hit, lookup_data,
           mem_st_valid, mem_st_addr, mem_st_data
  );
endinterface

// File: rtl/dcache_wb_buffer.sv
// Dcache victim write-back buffer: circular FIFO of dirty evicted lines that
// drains in push order to memory, coalesces repeat victims and answers load-miss lookups.
module dcache_wb_buffer #(
  parameter int WB_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  dcache_wb_buffer_if.slave   wb
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Byte-offset bits within a 64-bit line are not part of tag/set_index.
  localparam logic [63:0] LINE_MASK = ~64'h7;

  logic [WB_DEPTH-1:0] valid_q, valid_d;
  logic [63:0]         addr_q [WB_DEPTH];
  logic [63:0]         addr_d [WB_DEPTH];
  logic [63:0]         data_q [WB_DEPTH];
  logic [63:0]         data_d [WB_DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic             full;
  logic             pop;
  logic             push;
  logic             coal_hit;
  logic [PTR_W-1:0] coal_idx;
  logic             look_hit;
  logic [63:0]      look_data;

  function automatic logic line_match(input logic [63:0] a, input logic [63:0] b);
    return ((a ^ b) & LINE_MASK) == 64'd0;
  endfunction

  assign full = (count_q == CNT_W'(WB_DEPTH));

  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    head_d   = head_q;
    tail_d   = tail_q;
    coal_hit = 1'b0;
    coal_idx = '0;
    pop      = wb.mem_st_accept && valid_q[head_q];
    push     = wb.push_en && !full;

    // The head leaving this cycle is not a coalesce target: its old data is stored.
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (valid_q[i] && line_match(addr_q[i], wb.push_addr) &&
          !(pop && (PTR_W'(i) == head_q))) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    // Pointers wrap naturally because WB_DEPTH is a power of two.
    if (push) begin
      if (coal_hit) begin
        data_d[coal_idx] = wb.push_data;
      end else begin
        valid_d[tail_q] = 1'b1;
        addr_d[tail_q]  = wb.push_addr;
        data_d[tail_q]  = wb.push_data;
        tail_d          = tail_q + PTR_W'(1);
      end
    end

    count_d = count_q + CNT_W'(push && !coal_hit) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < WB_DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // At most one entry can match, so OR-ing the matching data needs no priority.
  always_comb begin
    look_hit  = 1'b0;
    look_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (wb.lookup_en && valid_q[i] && line_match(addr_q[i], wb.lookup_addr)) begin
        look_hit  = 1'b1;
        look_data = look_data | data_q[i];
      end
    end
  end

  assign wb.lookup_hit   = look_hit;
  assign wb.lookup_data  = look_data;
  assign wb.wb_full      = full;
  assign wb.wb_count     = count_q;
  assign wb.wb_empty     = (count_q == '0);
  assign wb.mem_st_valid = valid_q[head_q];
  assign wb.mem_st_addr  = valid_q[head_q] ? addr_q[head_q] : 64'd0;
  assign wb.mem_st_data  = valid_q[head_q] ? data_q[head_q] : 64'd0;

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer: directed scenarios plus a randomized
// run compared against an in-order queue model of the victim buffer.
module tb_dcache_wb_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  dcache_wb_buffer_if #(.WB_DEPTH(DEPTH)) bus ();

  dcache_wb_buffer #(.WB_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus.slave)
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    bus.push_en       = 1'b0;
    bus.push_addr     = 64'd0;
    bus.push_data     = 64'd0;
    bus.lookup_en     = 1'b0;
    bus.lookup_addr   = 64'd0;
    bus.mem_st_accept = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [63:0] a, input logic [63:0] d);
    bus.push_en   = 1'b1;
    bus.push_addr = a;
    bus.push_data = d;
    tick();
    bus.push_en   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.lookup_en   = 1'b1;
    bus.lookup_addr = 64'h100;
    #1;
    checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.wb_empty); end
    checks++; if (bus.mem_st_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.mem_st_valid); end
    checks++; if (bus.wb_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.wb_count); end
    checks++; if (bus.wb_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.wb_full); end
    checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", bus.lookup_hit); end
    checks++; if (bus.lookup_data !== 64'd0) begin errors++; $display("FAIL reset_ldata: got %0h want 0", bus.lookup_data); end
    checks++; if (bus.mem_st_addr !== 64'd0) begin errors++; $display("FAIL reset_st_addr: got %0h want 0", bus.mem_st_addr); end
    checks++; if (bus.mem_st_data !== 64'd0) begin errors++; $display("FAIL reset_st_data: got %0h want 0", bus.mem_st_data); end
    bus.lookup_en = 1'b0;
  endtask

  task automatic test_single_push();
    do_reset();
    push_one(64'h100, 64'hAA);
    bus.lookup_en   = 1'b1;
    bus.lookup_addr = 64'h100;
    #1;
    checks++; if (bus.mem_st_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.mem_st_valid); end
    checks++; if (bus.mem_st_addr !== 64'h100) begin errors++; $display("FAIL single_addr: got %0h want 100", bus.mem_st_addr); end
    checks++; if (bus.mem_st_data !== 64'hAA) begin errors++; $display("FAIL single_data: got %0h want aa", bus.mem_st_data); end
    checks++; if (bus.wb_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.wb_count); end
    checks++; if (bus.lookup_hit !== 1'b1) begin errors++; $display("FAIL single_hit: got %b want 1", bus.lookup_hit); end
    checks++; if (bus.lookup_data !== 64'hAA) begin errors++; $display("FAIL single_ldata: got %0h want aa", bus.lookup_data); end
    bus.mem_st_accept = 1'b1;
    tick();
    bus.mem_st_accept = 1'b0;
    #1;
    checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL single_drained: got %b want 1", bus.wb_empty); end
    checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL single_hit_after: got %b want 0", bus.lookup_hit); end
    bus.lookup_en = 1'b0;
  endtask

  task automatic test_fill();
    logic [63:0] exp_addr [4];
    exp_addr = '{64'h8, 64'h10, 64'h18, 64'h20};
    do_reset();
    for (int i = 0; i < 4; i++) push_one(64'(i * 8), 64'h1000 + 64'(i));
    #1;
    checks++; if (bus.wb_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.wb_full); end
    checks++; if (bus.wb_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", bus.wb_count); end
    checks++; if (bus.mem_st_addr !== 64'h0) begin errors++; $display("FAIL fill_head: got %0h want 0", bus.mem_st_addr); end
    bus.push_en       = 1'b1;
    bus.push_addr     = 64'h20;
    bus.push_data     = 64'h2020;
    bus.mem_st_accept = 1'b1;
    tick();
    bus.push_en       = 1'b0;
    bus.mem_st_accept = 1'b0;
    bus.lookup_en     = 1'b1;
    bus.lookup_addr   = 64'h20;
    #1;
    checks++; if (bus.wb_count !== 3'd3) begin errors++; $display("FAIL full_push_count: got %0d want 3", bus.wb_count); end
    checks++; if (bus.mem_st_addr !== 64'h8) begin errors++; $display("FAIL full_push_head: got %0h want 8", bus.mem_st_addr); end
    checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL full_push_ignored: got %b want 0", bus.lookup_hit); end
    push_one(64'h20, 64'h2020);
    #1;
    checks++; if (bus.wb_full !== 1'b1) begin errors++; $display("FAIL wrap_full: got %b want 1", bus.wb_full); end
    checks++; if (bus.lookup_data !== 64'h2020) begin errors++; $display("FAIL wrap_ldata: got %0h want 2020", bus.lookup_data); end
    bus.lookup_en     = 1'b0;
    bus.mem_st_accept = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (bus.mem_st_addr !== exp_addr[j]) begin errors++; $display("FAIL drain_order[%0d]: got %0h want %0h", j, bus.mem_st_addr, exp_addr[j]); end
      tick();
    end
    bus.mem_st_accept = 1'b0;
    #1;
    checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL fill_drained: got %b want 1", bus.wb_empty); end
  endtask

  task automatic test_coalesce();
    do_reset();
    push_one(64'h40, 64'h1);
    push_one(64'h40, 64'h2);
    #1;
    checks++; if (bus.wb_count !== 3'd1) begin errors++; $display("FAIL coal_count: got %0d want 1", bus.wb_count); end
    checks++; if (bus.mem_st_addr !== 64'h40) begin errors++; $display("FAIL coal_addr: got %0h want 40", bus.mem_st_addr); end
    checks++; if (bus.mem_st_data !== 64'h2) begin errors++; $display("FAIL coal_data: got %0h want 2", bus.mem_st_data); end
    bus.mem_st_accept = 1'b1;
    tick();
    bus.mem_st_accept = 1'b0;
    #1;
    checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL coal_drained: got %b want 1", bus.wb_empty); end
  endtask

  task automatic test_coalesce_head_pop();
    do_reset();
    push_one(64'h40, 64'h1);
    bus.push_en       = 1'b1;
    bus.push_addr     = 64'h40;
    bus.push_data     = 64'h2;
    bus.mem_st_accept = 1'b1;
    #1;
    checks++; if (bus.mem_st_data !== 64'h1) begin errors++; $display("FAIL headpop_old: got %0h want 1", bus.mem_st_data); end
    tick();
    bus.push_en       = 1'b0;
    bus.mem_st_accept = 1'b0;
    #1;
    checks++; if (bus.wb_count !== 3'd1) begin errors++; $display("FAIL headpop_count: got %0d want 1", bus.wb_count); end
    checks++; if (bus.mem_st_addr !== 64'h40) begin errors++; $display("FAIL headpop_addr: got %0h want 40", bus.mem_st_addr); end
    checks++; if (bus.mem_st_data !== 64'h2) begin errors++; $display("FAIL headpop_new: got %0h want 2", bus.mem_st_data); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 3; i++) push_one(64'h200 + 64'(i * 8), 64'hBEEF + 64'(i));
    bus.mem_st_accept = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_st_accept = 1'b0;
    #1;
    checks++; if (bus.wb_count !== 3'd0) begin errors++; $display("FAIL rst_drain_count: got %0d want 0", bus.wb_count); end
    checks++; if (bus.mem_st_valid !== 1'b0) begin errors++; $display("FAIL rst_drain_valid: got %b want 0", bus.mem_st_valid); end
    bus.lookup_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.lookup_addr = 64'h200 + 64'(i * 8);
      #1;
      checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL rst_drain_lookup[%0d]: got %b want 0", i, bus.lookup_hit); end
    end
    bus.lookup_en = 1'b0;
  endtask

  task automatic test_random(input int cycles);
    ent_t        q [$];
    logic        pe, acc, le, exp_hit;
    logic [63:0] pa, pd, la, exp_ld;
    int          k;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      pe  = (q.size() < DEPTH) && ($urandom_range(0, 99) < 55);
      pa  = 64'h1000 + 64'($urandom_range(0, 5) * 8);
      pd  = {$urandom, $urandom};
      acc = ($urandom_range(0, 99) < 40);
      le  = $urandom_range(0, 1) == 1;
      la  = 64'h1000 + 64'($urandom_range(0, 6) * 8);
      bus.push_en = pe; bus.push_addr = pa; bus.push_data = pd;
      bus.mem_st_accept = acc; bus.lookup_en = le; bus.lookup_addr = la;
      #1;
      exp_hit = 1'b0;
      exp_ld  = 64'd0;
      foreach (q[i]) if (le && q[i].a == la) begin exp_hit = 1'b1; exp_ld = q[i].d; end
      checks++; if (bus.mem_st_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", c, bus.mem_st_valid, q.size() > 0); end
      checks++; if (bus.mem_st_addr !== (q.size() > 0 ? q[0].a : 64'd0)) begin errors++; $display("FAIL rnd_addr @%0d: got %0h want %0h", c, bus.mem_st_addr, q.size() > 0 ? q[0].a : 64'd0); end
      checks++; if (bus.mem_st_data !== (q.size() > 0 ? q[0].d : 64'd0)) begin errors++; $display("FAIL rnd_data @%0d: got %0h want %0h", c, bus.mem_st_data, q.size() > 0 ? q[0].d : 64'd0); end
      checks++; if (bus.wb_count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count @%0d: got %0d want %0d", c, bus.wb_count, q.size()); end
      checks++; if (bus.wb_full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full @%0d: got %b want %b", c, bus.wb_full, q.size() == DEPTH); end
      checks++; if (bus.wb_empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty @%0d: got %b want %b", c, bus.wb_empty, q.size() == 0); end
      checks++; if (bus.lookup_hit !== exp_hit) begin errors++; $display("FAIL rnd_hit @%0d: got %b want %b", c, bus.lookup_hit, exp_hit); end
      checks++; if (bus.lookup_data !== exp_ld) begin errors++; $display("FAIL rnd_ldata @%0d: got %0h want %0h", c, bus.lookup_data, exp_ld); end
      tick();
      // Reference behaviour: the head leaves first, then a push updates a surviving twin or appends.
      if (acc && q.size() > 0) void'(q.pop_front());
      if (pe) begin
        k = -1;
        foreach (q[i]) if (q[i].a == pa) k = i;
        if (k >= 0) q[k].d = pd;
        else q.push_back('{a: pa, d: pd});
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_push();
    test_fill();
    test_coalesce();
    test_coalesce_head_pop();
    test_reset_mid_drain();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
